// File: rtl/sdhcal_daq_pkg.sv
// Shared types and constants for the SDHCAL DAQ HOLD sampler.
// Provides the sampler state enum, flag bit indices and a shift clamp helper.
package sdhcal_daq_pkg;

  localparam int ADC_W_DEF = 12;

  localparam int FLG_EARLY = 0;
  localparam int FLG_OTR   = 1;
  localparam int FLG_TMO   = 2;
  localparam int FLG_OVR   = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    EMIT   = 3'd4
  } state_t;

  function automatic logic [2:0] clamp_shift(
    input logic [2:0] s,
    input logic [2:0] mx
  );
    return (s > mx) ? mx : s;
  endfunction

endpackage

// File: rtl/sampler_accum.sv
// Sample accumulator: sums ADC samples, counts them, divides by 2^shift.
// Ports: clk/rst, clr (start new burst), add (take din), shift, avg, last.
module sampler_accum
  import sdhcal_daq_pkg::*;
#(
  parameter int ADC_W     = ADC_W_DEF,
  parameter int MAX_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add,
  input  logic [ADC_W-1:0] din,
  input  logic [2:0]       shift,
  output logic [ADC_W-1:0] avg,
  output logic             last
);

  localparam int AW = ADC_W + MAX_SHIFT;

  logic [AW-1:0]        acc_q, acc_d;
  logic [MAX_SHIFT-1:0] cnt_q, cnt_d;
  logic [MAX_SHIFT:0]   n_samp;
  logic [MAX_SHIFT-1:0] cnt_max;
  logic [AW-1:0]        quot;
  logic [MAX_SHIFT-1:0] unused_hi;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add) begin
      acc_d = acc_q + AW'(din);
      cnt_d = cnt_q + MAX_SHIFT'(1);
    end
  end

  // Burst length is 2^shift; last marks the final sample index.
  assign n_samp  = (MAX_SHIFT+1)'(1) << shift;
  assign cnt_max = MAX_SHIFT'(n_samp - (MAX_SHIFT+1)'(1));
  assign last    = (cnt_q == cnt_max);

  // Partial bursts are still divided by the full 2^shift.
  assign quot      = acc_q >> shift;
  assign avg       = quot[ADC_W-1:0];
  assign unused_hi = quot[AW-1:ADC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hold_adc_sampler.sv
// HOLD-triggered ADC sampler: settle, convert 2^shift samples, average, emit.
// Ports: Clk/reset, Sample_en, HOLD, SettleDelay, SampleShift, Adc_* handshake,
// Data_out/Data_valid/Data_ready result handshake, Busy.
// Optional watchdog on Adc_Done enabled by macro ADC_TIMEOUT_EN.
module hold_adc_sampler
  import sdhcal_daq_pkg::*;
#(
  parameter int ADC_W     = ADC_W_DEF,
  parameter int MAX_SHIFT = 4,
  parameter int TMO_CYC   = 1023
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             Sample_en,
  input  logic             HOLD,
  input  logic [9:0]       SettleDelay,
  input  logic [2:0]       SampleShift,
  output logic             Adc_Start,
  input  logic             Adc_Done,
  input  logic [ADC_W-1:0] Adc_Data,
  input  logic             Adc_Otr,
  output logic [15:0]      Data_out,
  output logic             Data_valid,
  input  logic             Data_ready,
  output logic             Busy
);

  state_t      state_q, state_d;
  logic        hold_q;
  logic [9:0]  dly_q, dly_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [2:0]  shift_q, shift_d;
  logic        early_q, early_d;
  logic        otr_q, otr_d;
  logic        ovr_q, ovr_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        rise;
  logic        tmo_flag;
  logic [3:0]  flags;

  logic             acc_clr;
  logic             acc_add;
  logic [ADC_W-1:0] avg;
  logic             last;

`ifdef ADC_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] wdog_q, wdog_d;
  logic          tmo_q, tmo_d;
  assign tmo_flag = tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
  assign tmo_flag   = 1'b0;
`endif

  assign rise = HOLD & ~hold_q;

  sampler_accum #(
    .ADC_W     (ADC_W),
    .MAX_SHIFT (MAX_SHIFT)
  ) u_accum (
    .clk   (Clk),
    .rst   (reset),
    .clr   (acc_clr),
    .add   (acc_add),
    .din   (Adc_Data),
    .shift (shift_q),
    .avg   (avg),
    .last  (last)
  );

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    early_d   = early_q;
    otr_d     = otr_q;
    ovr_d     = ovr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;
    Adc_Start = 1'b0;
    flags     = '0;
`ifdef ADC_TIMEOUT_EN
    wdog_d    = wdog_q;
    tmo_d     = tmo_q;
`endif

    // A trigger while busy is dropped, only remembered as overrun.
    if (rise && state_q != IDLE) ovr_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (rise && Sample_en) begin
          dly_d   = SettleDelay;
          shift_d = clamp_shift(SampleShift, 3'(MAX_SHIFT));
          cnt_d   = '0;
          acc_clr = 1'b1;
          early_d = 1'b0;
          otr_d   = 1'b0;
          ovr_d   = 1'b0;
`ifdef ADC_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (!HOLD) begin
          early_d = 1'b1;
          state_d = EMIT;
        end else if (cnt_q == dly_q) begin
          state_d = START;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      START: begin
        // No request goes out once HOLD is gone.
        if (!HOLD) begin
          early_d = 1'b1;
          state_d = EMIT;
        end else begin
          Adc_Start = 1'b1;
          state_d   = WAIT;
`ifdef ADC_TIMEOUT_EN
          wdog_d    = '0;
`endif
        end
      end
      WAIT: begin
        // A requested conversion always completes.
        if (!HOLD) early_d = 1'b1;
        if (Adc_Done) begin
          acc_add = 1'b1;
          otr_d   = otr_q | Adc_Otr;
          state_d = (last || early_d) ? EMIT : START;
        end
`ifdef ADC_TIMEOUT_EN
        else if (wdog_q == TW'(TMO_CYC - 1)) begin
          tmo_d   = 1'b1;
          state_d = EMIT;
        end else begin
          wdog_d = wdog_q + TW'(1);
        end
`endif
      end
      EMIT: begin
        if (!valid_q) begin
          flags[FLG_OVR]   = ovr_d;
          flags[FLG_TMO]   = tmo_flag;
          flags[FLG_OTR]   = otr_q;
          flags[FLG_EARLY] = early_q;
          data_d  = {flags, avg};
          valid_d = 1'b1;
        end else begin
          // Only the overrun bit may change on a held word.
          if (rise) data_d[12+FLG_OVR] = 1'b1;
          if (Data_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= 1'b0;
      dly_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      early_q <= 1'b0;
      otr_q   <= 1'b0;
      ovr_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef ADC_TIMEOUT_EN
      wdog_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= HOLD;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      early_q <= early_d;
      otr_q   <= otr_d;
      ovr_q   <= ovr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef ADC_TIMEOUT_EN
      wdog_q  <= wdog_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign Data_out   = data_q;
  assign Data_valid = valid_q;
  assign Busy       = (state_q != IDLE);

endmodule
